// File: rtl/risc16b_mem_pkg.sv
// Shared types for the risc16b unified-memory arbiter: requester ids and
// the per-read tag carried down the return pipeline.
package risc16b_mem_pkg;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_id_t;

    typedef struct packed {
        logic     valid;
        port_id_t port;
    } tag_t;

    localparam logic [1:0] WE_NONE   = 2'b00;
    localparam tag_t       TAG_EMPTY = '{valid: 1'b0, port: PORT_I};

endpackage

// File: rtl/risc16b_mem_tagpipe.sv
// DEPTH-deep tag shift register; the tag pushed in cycle t appears at the
// output in cycle t+DEPTH, lining up with the memory's read data.
module risc16b_mem_tagpipe
    import risc16b_mem_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic in_valid_i,
    input  logic in_port_i,
    output logic out_valid_o,
    output logic out_port_o
);

    tag_t pipe_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < DEPTH; k++) pipe_q[k] <= TAG_EMPTY;
        end else begin
            pipe_q[0] <= '{valid: in_valid_i, port: port_id_t'(in_port_i)};
            for (int k = 1; k < DEPTH; k++) pipe_q[k] <= pipe_q[k-1];
        end
    end

    assign out_valid_o = pipe_q[DEPTH-1].valid;
    assign out_port_o  = pipe_q[DEPTH-1].port;

endmodule

// File: rtl/risc16b_mem_arb.sv
// Arbitrates the risc16b fetch and data ports onto one single-ported memory
// and steers returning read data back to the port that issued the read.
module risc16b_mem_arb
    import risc16b_mem_pkg::*;
#(
    parameter int READ_LAT = 1,
    parameter int RR_MODE  = 0,
    parameter int MAX_WAIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [15:0] i_rdata,
    input  logic        d_req,
    input  logic [15:0] d_addr,
    input  logic [1:0]  d_we,
    input  logic [15:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [15:0] d_rdata,
    output logic [15:0] mem_addr,
    output logic        mem_oe,
    output logic [1:0]  mem_we,
    output logic [15:0] mem_dout,
    input  logic [15:0] mem_din
);

    localparam logic [3:0] WAIT_SAT = 4'(MAX_WAIT);

    logic [3:0]  wait_q, wait_d;
    port_id_t    last_q, last_d;
    logic [15:0] addr_q, addr_d;
    logic        i_win, d_win, d_rd;
    logic        tp_valid, tp_port, rsp_valid;

    always_comb begin : arbitrate
        i_win = 1'b0;
        d_win = 1'b0;
        if (!rst) begin
            if (i_req && d_req) begin
                if (RR_MODE != 0) begin
                    d_win = (last_q == PORT_I);
                    i_win = !d_win;
                end else if (wait_q == WAIT_SAT) begin
                    i_win = 1'b1;
                end else begin
                    d_win = 1'b1;
                end
            end else begin
                i_win = i_req;
                d_win = d_req;
            end
        end
    end

    // Aging only counts while fetch is actually waiting; any gap resets it.
    always_comb begin : next_state
        wait_d = wait_q;
        if (!i_req || i_win)
            wait_d = '0;
        else if (wait_q != WAIT_SAT)
            wait_d = wait_q + 4'd1;

        last_d = last_q;
        if (i_win)
            last_d = PORT_I;
        else if (d_win)
            last_d = PORT_D;

        addr_d = addr_q;
        if (i_win)
            addr_d = i_addr;
        else if (d_win)
            addr_d = d_addr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q <= '0;
            last_q <= PORT_I;
            addr_q <= '0;
        end else begin
            wait_q <= wait_d;
            last_q <= last_d;
            addr_q <= addr_d;
        end
    end

    assign d_rd     = d_win && (d_we == WE_NONE);
    assign i_gnt    = i_win;
    assign d_gnt    = d_win;
    assign mem_addr = rst ? '0 : addr_d;
    assign mem_oe   = i_win || d_rd;
    assign mem_we   = d_win ? d_we : WE_NONE;
    assign mem_dout = (d_win && (d_we != WE_NONE)) ? d_wdata : '0;

    risc16b_mem_tagpipe #(.DEPTH(READ_LAT)) u_tagpipe (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (mem_oe),
        .in_port_i   (d_rd),
        .out_valid_o (tp_valid),
        .out_port_o  (tp_port)
    );

    // The pipe clears on the reset edge; masking here also keeps the first reset cycle quiet.
    assign rsp_valid = tp_valid && !rst;
    assign i_rvalid  = rsp_valid && !tp_port;
    assign d_rvalid  = rsp_valid && tp_port;
    assign i_rdata   = i_rvalid ? mem_din : '0;
    assign d_rdata   = d_rvalid ? mem_din : '0;

endmodule
